// File: rtl/portfolio_pkg.sv
// Shared definitions for the portfolio variance engine and the upstream covariance block.
// Default word format, FSM state encoding, accumulator sizing and packed matrix/vector types.
package portfolio_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int FRACT_DEF    = 8;
  localparam int N_STOCKS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pv_state_e;

  // Wide enough that a full N x N quadratic form of WIDTH-bit words never overflows.
  function automatic int acc_w(input int width, input int n);
    return 3 * width + 2 * $clog2(n);
  endfunction

  typedef logic [N_STOCKS_DEF-1:0][WIDTH_DEF-1:0]                    w_vec_t;
  typedef logic [N_STOCKS_DEF-1:0][N_STOCKS_DEF-1:0][WIDTH_DEF-1:0] cov_mat_t;

endpackage

// File: rtl/fxp_narrow.sv
// Signed fixed-point width reduction IN_W -> OUT_W.
// PORTFOLIO_VAR_SAT_EN defined: clamp to the OUT_W range and flag it; otherwise two's-complement wrap.
module fxp_narrow #(
  parameter int IN_W  = 52,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    sat_o
);

`ifdef PORTFOLIO_VAR_SAT_EN
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W:0] narrow_sat(input logic signed [IN_W-1:0] x);
    if (x > MAX_V) begin
      return {1'b1, MAX_V[OUT_W-1:0]};
    end else if (x < MIN_V) begin
      return {1'b1, MIN_V[OUT_W-1:0]};
    end
    return {1'b0, x[OUT_W-1:0]};
  endfunction

  assign {sat_o, dout_o} = narrow_sat(din_i);
`else
  logic unused_hi;

  assign dout_o    = din_i[OUT_W-1:0];
  assign sat_o     = 1'b0;
  assign unused_hi = ^din_i[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/portfolio_variance.sv
// Portfolio variance w'*Cov*w through a single time-multiplexed MAC, one matrix element per cycle.
// Output narrowing saturates when PORTFOLIO_VAR_SAT_EN is defined, wraps otherwise.
module portfolio_variance
  import portfolio_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRACT    = FRACT_DEF,
  parameter int N_STOCKS = N_STOCKS_DEF
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           valid_in,
  input  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]   cov_in,
  input  logic [N_STOCKS-1:0][WIDTH-1:0]                 w_in,
  output logic                                           ready_out,
  output logic                                           valid_out,
  output logic signed [WIDTH-1:0]                        var_out,
  output logic                                           sat_out
);

  localparam int ACC_W = acc_w(WIDTH, N_STOCKS);
  localparam int IDX_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STOCKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  pv_state_e                                     state_q, state_d;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]  cov_q, cov_d;
  logic [N_STOCKS-1:0][WIDTH-1:0]                w_q, w_d;
  logic [IDX_W-1:0]                              i_q, i_d, j_q, j_d;
  logic signed [ACC_W-1:0]                       row_acc_q, row_acc_d;
  logic signed [ACC_W-1:0]                       tot_acc_q, tot_acc_d;
  logic signed [WIDTH-1:0]                       var_q, var_d;
  logic                                          sat_q, sat_d;
  logic                                          valid_q, ready_q;

  logic signed [WIDTH-1:0]   cov_ij, w_j, w_i;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   row_sum, rowq, tot_sum, result;
  logic signed [WIDTH-1:0]   narrow_v;
  logic                      narrow_s;

  // MAC datapath: p = cov[i][j]*w[j]; at row end the scaled row sum is weighted by w[i].
  assign cov_ij  = $signed(cov_q[i_q][j_q]);
  assign w_j     = $signed(w_q[j_q]);
  assign w_i     = $signed(w_q[i_q]);
  assign prod    = (2*WIDTH)'(cov_ij) * (2*WIDTH)'(w_j);
  assign row_sum = row_acc_q + ACC_W'(prod);
  assign rowq    = row_sum >>> FRACT;
  assign tot_sum = tot_acc_q + ACC_W'(w_i) * rowq;
  assign result  = tot_sum >>> FRACT;

  fxp_narrow #(
    .IN_W (ACC_W),
    .OUT_W(WIDTH)
  ) u_narrow (
    .din_i (result),
    .dout_o(narrow_v),
    .sat_o (narrow_s)
  );

  always_comb begin
    state_d   = state_q;
    cov_d     = cov_q;
    w_d       = w_q;
    i_d       = i_q;
    j_d       = j_q;
    row_acc_d = row_acc_q;
    tot_acc_d = tot_acc_q;
    var_d     = var_q;
    sat_d     = sat_q;
    unique case (state_q)
      ACC: begin
        if (j_q == IDX_LAST) begin
          row_acc_d = '0;
          tot_acc_d = tot_sum;
          j_d       = '0;
          if (i_q == IDX_LAST) begin
            i_d     = '0;
            var_d   = narrow_v;
            sat_d   = narrow_s;
            state_d = DONE;
          end else begin
            i_d = i_q + IDX_ONE;
          end
        end else begin
          row_acc_d = row_sum;
          j_d       = j_q + IDX_ONE;
        end
      end
      default: begin
        // The result-pulse cycle also accepts, so held valid_in yields back-to-back jobs.
        state_d = IDLE;
        if (valid_in && ready_q) begin
          cov_d     = cov_in;
          w_d       = w_in;
          i_d       = '0;
          j_d       = '0;
          row_acc_d = '0;
          tot_acc_d = '0;
          state_d   = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cov_q     <= '0;
      w_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      row_acc_q <= '0;
      tot_acc_q <= '0;
      var_q     <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cov_q     <= cov_d;
      w_q       <= w_d;
      i_q       <= i_d;
      j_q       <= j_d;
      row_acc_q <= row_acc_d;
      tot_acc_q <= tot_acc_d;
      var_q     <= var_d;
      sat_q     <= sat_d;
      valid_q   <= (state_d == DONE);
      ready_q   <= (state_d != ACC);
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign var_out   = var_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_portfolio_variance.sv
// Scoreboard bench for portfolio_variance: driver queues expected results, monitor checks each valid_out.
module tb_portfolio_variance;
  import portfolio_pkg::*;

  typedef struct {
    logic [15:0] v;
    logic        s;
    int          acc;
    int          gap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  cov_mat_t    cov_in;
  w_vec_t      w_in;
  logic        ready_out;
  logic        valid_out;
  logic [15:0] var_out;
  logic        sat_out;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   last_acc = 0;

  portfolio_variance dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .cov_in   (cov_in),
    .w_in     (w_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .var_out  (var_out),
    .sat_out  (sat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values while rst_n is low, scoreboard pop on each result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_ready", ready_out, 1);
      chk("reset_valid", valid_out, 0);
      chk("reset_var", var_out, 0);
      chk("reset_sat", sat_out, 0);
    end else if (valid_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("var_out", $signed(var_out), $signed(e.v));
        chk("sat_out", sat_out, e.s);
        chk("latency", cyc - e.acc, 16);
        if (e.gap != 0) chk("job_spacing", e.acc - last_acc, e.gap);
        last_acc = e.acc;
      end
    end
  end

  function automatic void model(input cov_mat_t c, input w_vec_t w,
                                output logic [15:0] v, output logic s);
    longint tot, row, rowq, res;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      row = 0;
      for (int j = 0; j < 4; j++) row += longint'($signed(c[i][j])) * longint'($signed(w[j]));
      rowq = row >>> 8;
      tot += longint'($signed(w[i])) * rowq;
    end
    res = tot >>> 8;
`ifdef PORTFOLIO_VAR_SAT_EN
    if (res > 32767) begin
      v = 16'h7FFF; s = 1'b1;
    end else if (res < -32768) begin
      v = 16'h8000; s = 1'b1;
    end else begin
      v = res[15:0]; s = 1'b0;
    end
`else
    v = res[15:0];
    s = 1'b0;
`endif
  endfunction

  task automatic run_job(input cov_mat_t c, input w_vec_t w, input logic [15:0] ev,
                         input logic es, input bit push);
    int n;
    exp_t e;
    @(posedge clk); #1;
    cov_in   = c;
    w_in     = w;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) begin
      $display("FAIL ready_timeout actual=0 expected=1");
      $fatal(1, "ready_out never asserted");
    end
    if (push) begin
      e.v = ev; e.s = es; e.acc = cyc + 1; e.gap = 0;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  initial begin
    cov_mat_t    c;
    w_vec_t      w;
    logic [15:0] mv;
    logic        ms;
    exp_t        e;
    int          accepted;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    cov_in   = '0;
    w_in     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity covariance, equal weights of 0.25
    c = '0;
    for (int i = 0; i < 4; i++) c[i][i] = 16'd256;
    for (int i = 0; i < 4; i++) w[i] = 16'd64;
    run_job(c, w, 16'd64, 1'b0, 1'b1);

    // Single stock: only cov[0][0] may contribute
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c[i][j] = 16'(1000 + 37 * (4 * i + j));
    c[0][0] = 16'd300;
    w = '0;
    w[0] = 16'd256;
    run_job(c, w, 16'd300, 1'b0, 1'b1);

    // Negative covariance between stocks 0 and 1
    c = '0;
    c[0][0] = 16'd256;
    c[1][1] = 16'd256;
    c[0][1] = 16'hFF80;
    c[1][0] = 16'hFF80;
    w = '0;
    w[0] = 16'd256;
    w[1] = 16'd256;
    run_job(c, w, 16'd256, 1'b0, 1'b1);

    // Overflow of the output word
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c[i][j] = 16'h7FFF;
    for (int i = 0; i < 4; i++) w[i] = 16'd256;
`ifdef PORTFOLIO_VAR_SAT_EN
    run_job(c, w, 16'h7FFF, 1'b1, 1'b1);
`else
    run_job(c, w, 16'hFFF0, 1'b0, 1'b1);
`endif

    // valid_in held high with data changing every cycle
    accepted = 0;
    @(posedge clk); #1;
    valid_in = 1'b1;
    for (int n = 0; n < 120 && accepted < 3; n++) begin
      for (int i = 0; i < 4; i++) begin
        w_in[i] = 16'($urandom_range(0, 1024)) - 16'd512;
        for (int j = 0; j < 4; j++) cov_in[i][j] = 16'($urandom_range(0, 2000)) - 16'd1000;
      end
      if (ready_out) begin
        model(cov_in, w_in, mv, ms);
        e.v = mv; e.s = ms; e.acc = cyc + 1; e.gap = (accepted == 0) ? 0 : 17;
        sb_q.push_back(e);
        accepted++;
      end
      if (accepted < 3) begin
        @(posedge clk); #1;
      end
    end
    if (accepted < 3) begin
      $display("FAIL back_to_back_accepts actual=%0d expected=3", accepted);
      $fatal(1, "back-to-back acceptance stalled");
    end
    @(posedge clk); #1;
    valid_in = 1'b0;

    // Abort a job 5 cycles into accumulation
    for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(posedge clk);
    c = '0;
    for (int i = 0; i < 4; i++) c[i][i] = 16'd256;
    for (int i = 0; i < 4; i++) w[i] = 16'd64;
    run_job(c, w, 16'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);

    // Job after the abort
    c = '0;
    c[0][0] = 16'd256;
    c[1][1] = 16'd256;
    c[0][1] = 16'hFF80;
    c[1][0] = 16'hFF80;
    w = '0;
    w[0] = 16'd256;
    w[1] = 16'd256;
    run_job(c, w, 16'd256, 1'b0, 1'b1);

    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL pending_results actual=%0d expected=0", sb_q.size());
      $fatal(1, "results missing");
    end
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
